// File: rtl/noc_vc_input_buffer.sv
// Router input port buffer: one circular FIFO per virtual channel, a round-robin
// output selector that holds its choice while stalled, and registered credit return.
module noc_vc_input_buffer #(
  parameter int DATA_WIDTH = 528,
  parameter int VC_NUM     = 4,
  parameter int VC_DEPTH   = 16,
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int CW = $clog2(VC_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flit_valid_in,
  input  logic [VW-1:0]          flit_vc_in,
  input  logic [DATA_WIDTH-1:0]  flit_data_in,
  output logic [VC_NUM-1:0]      credit_out,
  output logic                   out_valid,
  output logic [VW-1:0]          out_vc,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic [VC_NUM*CW-1:0]   vc_count,
  output logic                   overflow_error
);

  localparam int PW = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(VC_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(VC_DEPTH - 1);
  localparam logic [VW-1:0] LAST_VC  = VW'(VC_NUM - 1);

  logic [VC_NUM-1:0]     not_empty;
  logic [VC_NUM-1:0]     full;
  logic [VC_NUM-1:0]     push_vc;
  logic [VC_NUM-1:0]     pop_vc;
  logic [DATA_WIDTH-1:0] head_data [VC_NUM];

  logic [VW-1:0]     rr_ptr_reg;
  logic [VW-1:0]     lock_vc_reg;
  logic              lock_reg;
  logic [VW-1:0]     sel_vc;
  logic              transfer;
  logic              push_accepted;
  logic [VC_NUM-1:0] credit_reg;
  logic              overflow_reg;

  // First non-empty VC found when scanning upward from start, wrapping at VC_NUM.
  function automatic logic [VW-1:0] rr_pick(input logic [VC_NUM-1:0] ne,
                                            input logic [VW-1:0] start);
    logic [VW-1:0] idx;
    logic [VW-1:0] pick;
    logic          found;
    idx   = start;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < VC_NUM; i++) begin
      if (!found && ne[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = (idx == LAST_VC) ? '0 : idx + 1'b1;
    end
    return pick;
  endfunction

  // A stalled offer stays pinned so late arrivals on other VCs cannot reorder it.
  assign sel_vc        = lock_reg ? lock_vc_reg : rr_pick(not_empty, rr_ptr_reg);
  assign out_valid     = |not_empty;
  assign out_vc        = sel_vc;
  assign out_data      = head_data[sel_vc];
  assign transfer      = out_valid && out_ready;
  assign push_accepted = |push_vc;
  assign credit_out     = credit_reg;
  assign overflow_error = overflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
      logic [PW-1:0]         rd_ptr_reg;
      logic [PW-1:0]         wr_ptr_reg;
      logic [CW-1:0]         count_reg;
      logic [DATA_WIDTH-1:0] mem [VC_DEPTH];

      // Full is judged on the pre-edge count, so a same-cycle pop never frees room.
      assign not_empty[gi] = (count_reg != '0);
      assign full[gi]      = (count_reg == DEPTH_C);
      assign push_vc[gi]   = flit_valid_in && (flit_vc_in == VW'(gi)) && !full[gi];
      assign pop_vc[gi]    = transfer && (sel_vc == VW'(gi));
      assign head_data[gi] = mem[rd_ptr_reg];
      assign vc_count[gi*CW +: CW] = count_reg;

      always_ff @(posedge clk) begin
        if (push_vc[gi]) begin
          mem[wr_ptr_reg] <= flit_data_in;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push_vc[gi]) begin
            wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
          end
          if (pop_vc[gi]) begin
            rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
          end
          case ({push_vc[gi], pop_vc[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg   <= '0;
      lock_reg     <= 1'b0;
      lock_vc_reg  <= '0;
      credit_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      credit_reg <= pop_vc;
      if (transfer) begin
        rr_ptr_reg <= (sel_vc == LAST_VC) ? '0 : sel_vc + 1'b1;
        lock_reg   <= 1'b0;
      end else if (out_valid) begin
        lock_reg    <= 1'b1;
        lock_vc_reg <= sel_vc;
      end
      // Any presented flit that found no room (full VC or nonexistent VC) is lost.
      if (flit_valid_in && !push_accepted) begin
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Randomized bench for noc_vc_input_buffer against an arrival-ordered flit list model.
module tb_noc_vc_input_buffer;

  localparam int DW    = 64;
  localparam int NV    = 4;
  localparam int DEPTH = 16;
  localparam int VW    = 2;
  localparam int CW    = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flit_valid_in = 1'b0;
  logic [VW-1:0]     flit_vc_in = '0;
  logic [DW-1:0]     flit_data_in = '0;
  logic [NV-1:0]     credit_out;
  logic              out_valid;
  logic [VW-1:0]     out_vc;
  logic [DW-1:0]     out_data;
  logic              out_ready = 1'b0;
  logic [NV*CW-1:0]  vc_count;
  logic              overflow_error;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  noc_vc_input_buffer #(.DATA_WIDTH(DW), .VC_NUM(NV), .VC_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .flit_valid_in(flit_valid_in), .flit_vc_in(flit_vc_in), .flit_data_in(flit_data_in),
    .credit_out(credit_out), .out_valid(out_valid), .out_vc(out_vc), .out_data(out_data),
    .out_ready(out_ready), .vc_count(vc_count), .overflow_error(overflow_error)
  );

  // Model: every buffered flit in arrival order, tagged with its VC.
  typedef struct { int vc; logic [DW-1:0] d; } ent_t;
  ent_t          mq[$];
  int            m_rr;
  bit            m_lock;
  int            m_lock_vc;
  logic [NV-1:0] m_credit;
  bit            m_ovf;

  function automatic int m_cnt(int v);
    int c = 0;
    for (int i = 0; i < mq.size(); i++) if (mq[i].vc == v) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] m_head(int v);
    for (int i = 0; i < mq.size(); i++) if (mq[i].vc == v) return mq[i].d;
    return '0;
  endfunction

  function automatic int m_sel();
    if (m_lock) return m_lock_vc;
    for (int i = 0; i < NV; i++) if (m_cnt((m_rr + i) % NV) > 0) return (m_rr + i) % NV;
    return 0;
  endfunction

  function automatic void m_pop(int v);
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].vc == v) begin
        mq.delete(i);
        return;
      end
    end
  endfunction

  function automatic logic [NV*CW-1:0] m_counts();
    logic [NV*CW-1:0] r;
    r = '0;
    for (int v = 0; v < NV; v++) r[v*CW +: CW] = CW'(m_cnt(v));
    return r;
  endfunction

  function automatic void m_clear();
    mq.delete();
    m_rr = 0; m_lock = 0; m_lock_vc = 0; m_credit = '0; m_ovf = 0;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom};
  endfunction

  // One clock: drive at the current negedge, update the model at the posedge, return at the next negedge.
  task automatic cycle(input bit v, input int vc, input logic [DW-1:0] d, input bit rdy);
    bit any;
    int sel;
    int pre;
    flit_valid_in = v; flit_vc_in = VW'(vc); flit_data_in = d; out_ready = rdy;
    any = (mq.size() != 0);
    sel = m_sel();
    pre = m_cnt(vc);
    @(posedge clk);
    m_credit = '0;
    if (any && rdy) begin
      m_pop(sel);
      m_credit[sel] = 1'b1;
      m_rr = (sel + 1) % NV;
    end
    if (v) begin
      if (vc < NV && pre < DEPTH) mq.push_back('{vc: vc, d: d});
      else m_ovf = 1;
    end
    m_lock = any && !rdy;
    m_lock_vc = sel;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    m_clear();
    #1;
  endtask

  task automatic release_reset();
    for (int i = 0; i < 2; i++) begin
      flit_valid_in = 1'b1; flit_vc_in = VW'($urandom); flit_data_in = rand_data(); out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b1; flit_valid_in = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL por_valid: got %0h want 0", out_valid); end
    n_cmp++; if (credit_out !== '0) begin n_err++; $display("FAIL por_credit: got %0h want 0", credit_out); end
    n_cmp++; if (vc_count !== '0) begin n_err++; $display("FAIL por_count: got %0h want 0", vc_count); end
    n_cmp++; if (overflow_error !== 1'b0) begin n_err++; $display("FAIL por_ovf: got %0h want 0", overflow_error); end
    release_reset();
    for (int i = 0; i < 6; i++) cycle(1, int'($urandom_range(0, NV-1)), rand_data(), 0);
    cycle(0, 0, '0, 1);
    n_cmp++; if (vc_count !== m_counts()) begin n_err++; $display("FAIL pre_reset_count: got %0h want %0h", vc_count, m_counts()); end
    n_cmp++; if (credit_out !== m_credit) begin n_err++; $display("FAIL pre_reset_credit: got %0h want %0h", credit_out, m_credit); end
    apply_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h want 0", out_valid); end
    n_cmp++; if (credit_out !== '0) begin n_err++; $display("FAIL rst_credit: got %0h want 0", credit_out); end
    n_cmp++; if (vc_count !== '0) begin n_err++; $display("FAIL rst_count: got %0h want 0", vc_count); end
    n_cmp++; if (overflow_error !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %0h want 0", overflow_error); end
    release_reset();
    n_cmp++; if (vc_count !== '0) begin n_err++; $display("FAIL rst_no_accept: got %0h want 0", vc_count); end
    d = rand_data();
    flit_valid_in = 1'b1; flit_vc_in = 2'd1; flit_data_in = d; out_ready = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass: got %0h want 0", out_valid); end
    cycle(1, 1, d, 0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %0h want 1", out_valid); end
    n_cmp++; if (out_vc !== 2'd1) begin n_err++; $display("FAIL first_vc: got %0h want 1", out_vc); end
    n_cmp++; if (out_data !== d) begin n_err++; $display("FAIL first_data: got %0h want %0h", out_data, d); end
    $display("test_reset done");
  endtask

  task automatic test_single_vc();
    logic [DW-1:0] d [3];
    int pulses = 0;
    apply_reset(); release_reset();
    for (int i = 0; i < 3; i++) d[i] = rand_data();
    for (int i = 0; i < 6; i++) begin
      cycle(i < 3, 2, (i < 3) ? d[i] : '0, 1);
      pulses += int'(credit_out[2]);
      n_cmp++; if (credit_out !== m_credit) begin n_err++; $display("FAIL single_credit[%0d]: got %0h want %0h", i, credit_out, m_credit); end
      if (i < 3) begin
        n_cmp++; if (out_vc !== 2'd2) begin n_err++; $display("FAIL single_vc[%0d]: got %0h want 2", i, out_vc); end
        n_cmp++; if (out_data !== d[i]) begin n_err++; $display("FAIL single_data[%0d]: got %0h want %0h", i, out_data, d[i]); end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_empty[%0d]: got %0h want 0", i, out_valid); end
      end
    end
    n_cmp++; if (pulses !== 3) begin n_err++; $display("FAIL single_pulses: got %0d want 3", pulses); end
    $display("test_single_vc done");
  endtask

  task automatic test_round_robin();
    apply_reset(); release_reset();
    for (int r = 0; r < 2; r++) for (int v = 0; v < NV; v++) cycle(1, v, rand_data(), 0);
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (out_vc !== VW'(i % NV)) begin n_err++; $display("FAIL rr_vc[%0d]: got %0h want %0h", i, out_vc, i % NV); end
      n_cmp++; if (out_data !== m_head(m_sel())) begin n_err++; $display("FAIL rr_data[%0d]: got %0h want %0h", i, out_data, m_head(m_sel())); end
      cycle(0, 0, '0, 1);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_drained: got %0h want 0", out_valid); end
    $display("test_round_robin done");
  endtask

  task automatic test_stall();
    logic [DW-1:0] d1;
    apply_reset(); release_reset();
    d1 = rand_data();
    cycle(1, 1, d1, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, rand_data(), 0);
      n_cmp++; if (out_vc !== 2'd1) begin n_err++; $display("FAIL stall_vc[%0d]: got %0h want 1", k, out_vc); end
      n_cmp++; if (out_data !== d1) begin n_err++; $display("FAIL stall_data[%0d]: got %0h want %0h", k, out_data, d1); end
    end
    n_cmp++; if (out_vc !== 2'd1) begin n_err++; $display("FAIL stall_release_vc: got %0h want 1", out_vc); end
    cycle(0, 0, '0, 1);
    n_cmp++; if (credit_out !== 4'b0010) begin n_err++; $display("FAIL stall_credit: got %0h want 2", credit_out); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (out_vc !== 2'd0) begin n_err++; $display("FAIL stall_drain_vc[%0d]: got %0h want 0", k, out_vc); end
      n_cmp++; if (out_data !== m_head(0)) begin n_err++; $display("FAIL stall_drain_data[%0d]: got %0h want %0h", k, out_data, m_head(0)); end
      cycle(0, 0, '0, 1);
    end
    $display("test_stall done");
  endtask

  task automatic test_overflow();
    apply_reset(); release_reset();
    for (int k = 0; k < DEPTH; k++) cycle(1, 3, rand_data(), 0);
    n_cmp++; if (vc_count[3*CW +: CW] !== 5'd16) begin n_err++; $display("FAIL ovf_full_count: got %0d want 16", vc_count[3*CW +: CW]); end
    n_cmp++; if (overflow_error !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %0h want 0", overflow_error); end
    cycle(1, 3, rand_data(), 1);
    n_cmp++; if (vc_count[3*CW +: CW] !== 5'd15) begin n_err++; $display("FAIL ovf_count: got %0d want 15", vc_count[3*CW +: CW]); end
    n_cmp++; if (overflow_error !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0h want 1", overflow_error); end
    n_cmp++; if (credit_out !== 4'b1000) begin n_err++; $display("FAIL ovf_credit: got %0h want 8", credit_out); end
    for (int k = 0; k < 3; k++) cycle(0, 0, '0, 0);
    n_cmp++; if (overflow_error !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0h want 1", overflow_error); end
    for (int k = 0; k < 15; k++) begin
      n_cmp++; if (out_data !== m_head(3)) begin n_err++; $display("FAIL ovf_drain_data[%0d]: got %0h want %0h", k, out_data, m_head(3)); end
      cycle(0, 0, '0, 1);
    end
    n_cmp++; if (vc_count !== '0) begin n_err++; $display("FAIL ovf_drained: got %0h want 0", vc_count); end
    $display("test_overflow done");
  endtask

  task automatic test_wrap();
    int pulses = 0;
    apply_reset(); release_reset();
    cycle(1, 0, rand_data(), 0);
    for (int k = 0; k < 40; k++) begin
      n_cmp++; if (out_data !== m_head(0)) begin n_err++; $display("FAIL wrap_data[%0d]: got %0h want %0h", k, out_data, m_head(0)); end
      cycle(1, 0, rand_data(), 1);
      pulses += int'(credit_out[0]);
      n_cmp++; if (vc_count[0 +: CW] !== 5'd1) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want 1", k, vc_count[0 +: CW]); end
    end
    n_cmp++; if (pulses !== 40) begin n_err++; $display("FAIL wrap_pulses: got %0d want 40", pulses); end
    $display("test_wrap done");
  endtask

  task automatic test_random();
    int rdy_pct;
    apply_reset(); release_reset();
    for (int i = 0; i < 600; i++) begin
      rdy_pct = (i < 250) ? 25 : ((i < 450) ? 70 : 95);
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, NV-1)), rand_data(),
            $urandom_range(0, 99) < rdy_pct);
      n_cmp++; if (out_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rand_valid[%0d]: got %0h want %0h", i, out_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_cmp++; if (out_vc !== VW'(m_sel())) begin n_err++; $display("FAIL rand_vc[%0d]: got %0h want %0h", i, out_vc, m_sel()); end
        n_cmp++; if (out_data !== m_head(m_sel())) begin n_err++; $display("FAIL rand_data[%0d]: got %0h want %0h", i, out_data, m_head(m_sel())); end
      end
      n_cmp++; if (vc_count !== m_counts()) begin n_err++; $display("FAIL rand_count[%0d]: got %0h want %0h", i, vc_count, m_counts()); end
      n_cmp++; if (credit_out !== m_credit) begin n_err++; $display("FAIL rand_credit[%0d]: got %0h want %0h", i, credit_out, m_credit); end
      n_cmp++; if (overflow_error !== m_ovf) begin n_err++; $display("FAIL rand_ovf[%0d]: got %0h want %0h", i, overflow_error, m_ovf); end
    end
    $display("test_random done");
  endtask

  initial begin
    m_clear();
    test_reset();
    test_single_vc();
    test_round_robin();
    test_stall();
    test_overflow();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/noc_vc_input_buffer.md
NOC_VC_INPUT_BUFFER -- requirements
Module: noc_vc_input_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 528: flit payload width in bits.
REQ-002 SHALL have parameter VC_NUM, default 4: number of virtual channels (VCs); VW = max(1,$clog2(VC_NUM)).
REQ-003 SHALL have parameter VC_DEPTH, default 16: flit entries per VC; CW = $clog2(VC_DEPTH+1).
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flit_valid_in  input  1  flit present from crossbar output; no backpressure.
REQ-007 SHALL have port flit_vc_in  input  VW  target VC of the incoming flit.
REQ-008 SHALL have port flit_data_in  input  DATA_WIDTH  incoming flit payload.
REQ-009 SHALL have port credit_out  output  VC_NUM  one-cycle pulse per freed entry, bit v = VC v.
REQ-010 SHALL have port out_valid  output  1  a buffered flit is offered downstream.
REQ-011 SHALL have port out_vc  output  VW  VC of the offered flit.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  payload of the offered flit.
REQ-013 SHALL have port out_ready  input  1  downstream accepts; transfer = out_valid && out_ready.
REQ-014 SHALL have port vc_count  output  VC_NUM*CW  per-VC occupancy, VC v at bits [v*CW +: CW].
REQ-015 SHALL have port overflow_error  output  1  sticky protocol-violation flag.

Function
REQ-016 SHALL implement one independent circular FIFO per VC, with read pointer, write pointer and occupancy counter per VC.
REQ-017 SHALL write flit_data_in into FIFO flit_vc_in on a rising edge with flit_valid_in=1, when that VC's count < VC_DEPTH and flit_vc_in < VC_NUM.
REQ-018 SHALL drop a flit arriving to a full VC and set overflow_error. The full check uses the pre-edge count, so a same-cycle pop of that VC does not rescue it.
REQ-019 SHALL drop a flit with flit_vc_in >= VC_NUM and set overflow_error.
REQ-020 SHALL hold overflow_error at 1 until reset.
REQ-021 SHALL wrap read and write pointers from VC_DEPTH-1 to 0.
REQ-022 SHALL make a written flit visible at the output no earlier than the cycle after the write (1-cycle write-to-out latency); there is no combinational bypass.
REQ-023 SHALL drive out_valid=1 whenever any VC is non-empty.
REQ-024 SHALL drive out_vc/out_data from the head of the selected VC.
REQ-025 SHALL select among non-empty VCs round-robin. The search starts at rr_ptr and ascends with wrap.
REQ-026 SHALL advance rr_ptr to (selected VC + 1) mod VC_NUM on each transfer; with no transfer, rr_ptr holds.
REQ-027 SHALL lock the selection while out_valid && !out_ready: out_vc and out_data stay stable until the transfer, regardless of pushes to other VCs.
REQ-028 SHALL pop the head of the selected VC on each transfer, at most one flit per cycle.
REQ-029 SHALL pulse credit_out[v] for exactly one cycle, in the cycle after each pop from VC v (registered, 1-cycle latency).
REQ-030 SHALL keep credit_out at 0 in all other cycles.
REQ-031 SHALL, on a simultaneous push and pop on the same non-full VC, perform both and leave that VC's count unchanged.
REQ-032 SHALL, on a simultaneous push and pop on different VCs, update each VC's count independently.
REQ-033 SHALL give each VC an upstream credit budget of VC_DEPTH after reset; this budget is implicit and no initial credit pulses are sent.
REQ-034 SHALL drive vc_count as a registered value equal to the post-edge occupancy.

Reset
REQ-035 SHALL, on rst_n=0 (asynchronous, including mid-transfer), immediately drive to 0: all counts, all pointers, rr_ptr, the lock, credit_out, out_valid, vc_count and overflow_error.
REQ-036 SHALL discard buffered flits on reset; out_data is don't-care while out_valid=0.
REQ-037 SHALL accept no flit while rst_n=0.

Verification
REQ-038 Reset: assert rst_n=0 mid-stream with 5 flits buffered -> out_valid=0, credit_out=0, vc_count all 0, overflow_error=0; first flit after release appears 1 cycle after its write.
REQ-039 Single VC: push D0..D2 to VC2, out_ready=1 -> out_data D0,D1,D2 in order on consecutive cycles, out_vc=2, and credit_out[2] pulses once per pop, 1 cycle after each pop.
REQ-040 Round-robin: VC0..VC3 each hold 2 flits, out_ready=1 -> out_vc sequence 0,1,2,3,0,1,2,3.
REQ-041 Stall: out_ready=0 for 4 cycles with VC1 offered while VC0 receives pushes -> out_vc stays 1 and out_data stays stable; after out_ready=1, VC1 transfers first.
REQ-042 Overflow: 16 pushes to VC3 then a 17th with a same-cycle pop -> 17th dropped, overflow_error=1 sticky, vc_count[VC3]=15 after the edge.
REQ-043 Wrap and simultaneous: 40 interleaved push/pop on VC0 at occupancy 1 -> data order preserved across pointer wrap, count constant 1, 40 credit pulses.
